mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32IM pipeline.
- Consumes the EX/MEM register: ALU result used as the address, forwarded rs2 used as store data, plus control bits.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW over a req/gnt/rvalid data-memory port and stalls upstream while a transaction is outstanding.
- Drives the registered MEM/WB outputs that feed writeback and the MEM/WB forwarding path.

Parameters:
BUS_TIMEOUT, 15, max cycles spent in REQ+WAIT before abort; 0 disables timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  EX/MEM slot holds a valid instruction
alu_result_i  in  32  ALU/mul result; byte address for loads/stores
rs2_data_i  in  32  store data (already forwarded)
rd_addr_i  in  5  destination register
funct3_i  in  3  load/store width/sign
mem_read_i  in  1  load
mem_write_i  in  1  store
reg_write_i  in  1  writes rd
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1=store
dmem_addr_o  out  32  word address ({addr[31:2],2'b00})
dmem_wdata_o  out  32  lane-replicated store data
dmem_be_o  out  4  byte enables
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load word
stall_o  out  1  hold IF..EX/MEM (combinational)
wb_valid_o  out  1  MEM/WB slot valid
wb_result_o  out  32  load data or pass-through ALU result
wb_rd_addr_o  out  5  destination
wb_reg_write_o  out  1  regfile write enable
misaligned_o  out  1  one-cycle pulse: misaligned or illegal-funct3 access
bus_err_o  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: state=IDLE, timeout counter=0, all outputs 0. Reset mid-transaction abandons it; dmem_req_o drops immediately on rst_n low.
- FSM states: IDLE, REQ, WAIT.
- A mem op is valid_i & (mem_read_i | mem_write_i). If both bits are set, the op is treated as a load.
- Alignment/legality check in IDLE:
  - LH/LHU/SH with addr[0]!=0 is a fault.
  - LW/SW with addr[1:0]!=0 is a fault.
  - funct3 011/110/111 on a load, or ≥011 on a store, is a fault.
- IDLE, non-mem valid instruction: registered pass-through, 1-cycle latency.
  - wb_result_o=alu_result_i, rd and reg_write copied.
  - wb_valid_o=1.
- IDLE, faulting mem op: no bus activity. Next cycle: wb_valid_o=1, wb_reg_write_o=0, misaligned_o=1.
- IDLE, legal mem op: latch addr, funct3, rd, store lane data and byte enables; go to REQ. stall_o=1 this cycle.
- REQ: dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i.
  - Store: the gnt cycle completes it; stall_o=0 in that cycle; MEM/WB gets wb_valid_o=1, reg_write=0; go to IDLE.
  - Load: on gnt, go to WAIT with dmem_req_o=0 next cycle.
- WAIT: load only. rvalid is honoured only in WAIT (earliest one cycle after gnt).
  - On rvalid: stall_o=0; register the formatted data to wb_result_o with wb_reg_write_o=reg_write; go to IDLE.
- stall_o = (state==IDLE & legal mem op) | (state==REQ & !(store & gnt)) | (state==WAIT & !rvalid).
- Load formatting: select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Store data:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0].
  - SW: wdata=rs2, be=4'b1111.
- wb_reg_write_o is forced 0 when rd=0.
- When valid_i=0 in IDLE: wb_valid_o=0, wb_reg_write_o=0 next cycle.
- Timeout (BUS_TIMEOUT>0):
  - The counter clears on IDLE→REQ and increments every REQ/WAIT cycle.
  - When it reaches BUS_TIMEOUT: drop req, bus_err_o=1 for one cycle, emit wb_valid_o=1 with reg_write=0, stall_o=0, return to IDLE.
  - Timeout has priority over a same-cycle gnt/rvalid.
- Throughput: back-to-back non-mem instructions, 1/cycle. Minimum load occupancy 3 cycles (IDLE, REQ+gnt, WAIT+rvalid); store 2 cycles.

Test Plan:
- Pass-through ADD, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_result=0x1234, wb_rd=5, wb_reg_write=1, stall_o never high.
- LB at addr 0x103, gnt immediate, rvalid 2 cycles later with rdata=0x80FF_0000 -> dmem_addr=0x100; stall_o high until the rvalid cycle; wb_result=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at addr 0x202, rs2=0xDEAD_BEEF, gnt delayed 3 cycles -> dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, inputs stable while waiting; wb_reg_write=0.
- LW at addr 0x401 -> dmem_req_o stays 0; misaligned_o pulses one cycle; wb_valid=1, wb_reg_write=0; no stall.
- LW, gnt given, rvalid never arrives, BUS_TIMEOUT=15 -> bus_err_o pulses at cycle 15 after entering REQ; FSM returns to IDLE; a following ADD passes through normally.
- Reset asserted in WAIT -> dmem_req_o, stall_o and all wb outputs go 0 immediately; after release, a new LW at 0x0 with rdata=0x1122_3344 returns wb_result=0x1122_3344.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory bus for loads/stores and registers the MEM/WB outputs.
// Latency: 1 cycle pass-through; loads >= 3 cycles, stores >= 2 cycles; stall_o holds upstream while busy.
module mem_stage #(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic        wb_reg_write_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam bit          TO_EN  = (BUS_TIMEOUT > 0);
    localparam logic [31:0] TO_LIM = 32'(BUS_TIMEOUT);

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, cnt_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        regw_q, load_q;
    logic        wb_valid_q, wb_regw_q, misal_q, buserr_q;
    logic [31:0] wb_result_q;
    logic [4:0]  wb_rd_q;

    logic        mem_op, illegal_f3, misal, fault, legal, timeout;
    logic [31:0] st_wdata_d, ld_shift, ld_fmt_d;
    logic [3:0]  st_be_d;

    always_comb begin
        mem_op     = valid_i & (mem_read_i | mem_write_i);
        // mem_read wins when both bits are set, so it alone selects the legality table
        illegal_f3 = mem_read_i ? ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11))
                                : (funct3_i >= 3'b011);
        misal      = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                     ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0]));
        fault      = mem_op & (illegal_f3 | misal);
        legal      = mem_op & ~fault;
        timeout    = TO_EN && (state_q != IDLE) && ((cnt_q + 32'd1) == TO_LIM);
    end

    always_comb begin
        st_wdata_d = rs2_data_i;
        st_be_d    = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata_d = {4{rs2_data_i[7:0]}};
                st_be_d    = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                st_wdata_d = {2{rs2_data_i[15:0]}};
                st_be_d    = 4'b0011 << alu_result_i[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_fmt_d = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_fmt_d = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_fmt_d = {24'd0, ld_shift[7:0]};
            3'b101:  ld_fmt_d = {16'd0, ld_shift[15:0]};
            default: ld_fmt_d = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            be_q        <= '0;
            f3_q        <= '0;
            rd_q        <= '0;
            regw_q      <= 1'b0;
            load_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_regw_q   <= 1'b0;
            misal_q     <= 1'b0;
            buserr_q    <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            misal_q    <= 1'b0;
            buserr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (legal) begin
                        addr_q  <= alu_result_i;
                        wdata_q <= st_wdata_d;
                        be_q    <= mem_read_i ? 4'b1111 : st_be_d;
                        f3_q    <= funct3_i;
                        rd_q    <= rd_addr_i;
                        regw_q  <= reg_write_i;
                        load_q  <= mem_read_i;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end else if (valid_i) begin
                        wb_valid_q  <= 1'b1;
                        wb_result_q <= alu_result_i;
                        wb_rd_q     <= rd_addr_i;
                        wb_regw_q   <= reg_write_i & (|rd_addr_i) & ~fault;
                        misal_q     <= fault;
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (timeout) begin
                        buserr_q    <= 1'b1;
                        wb_valid_q  <= 1'b1;
                        wb_result_q <= addr_q;
                        wb_rd_q     <= rd_q;
                        state_q     <= IDLE;
                    end else if (state_q == REQ) begin
                        if (dmem_gnt_i) begin
                            if (load_q) begin
                                state_q <= WAIT;
                            end else begin
                                wb_valid_q  <= 1'b1;
                                wb_result_q <= addr_q;
                                wb_rd_q     <= rd_q;
                                state_q     <= IDLE;
                            end
                        end
                    end else if (dmem_rvalid_i) begin
                        wb_valid_q  <= 1'b1;
                        wb_result_q <= ld_fmt_d;
                        wb_rd_q     <= rd_q;
                        wb_regw_q   <= regw_q & (|rd_q);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rst_n gating keeps stall low during reset even with a legal op presented upstream
    assign stall_o = rst_n & (((state_q == IDLE) & legal) |
                              ((state_q == REQ)  & ~(~load_q & dmem_gnt_i) & ~timeout) |
                              ((state_q == WAIT) & ~dmem_rvalid_i & ~timeout));

    assign dmem_req_o     = (state_q == REQ) & ~timeout;
    assign dmem_we_o      = ~load_q & (state_q == REQ);
    assign dmem_addr_o    = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o   = wdata_q;
    assign dmem_be_o      = be_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_result_o    = wb_result_q;
    assign wb_rd_addr_o   = wb_rd_q;
    assign wb_reg_write_o = wb_regw_q;
    assign misaligned_o   = misal_q;
    assign bus_err_o      = buserr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, faults, timeout and mid-transaction reset.
module tb_mem_stage;

    logic        clk, rst_n;
    logic        valid_i, mem_read_i, mem_write_i, reg_write_i;
    logic [31:0] alu_result_i, rs2_data_i, dmem_rdata_i;
    logic [4:0]  rd_addr_i;
    logic [2:0]  funct3_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_result_o;
    logic [3:0]  dmem_be_o;
    logic        stall_o, wb_valid_o, wb_reg_write_o, misaligned_o, bus_err_o;
    logic [4:0]  wb_rd_addr_o;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int n;

    mem_stage #(.BUS_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_result_i(alu_result_i),
        .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_rd_addr_o(wb_rd_addr_o),
        .wb_reg_write_o(wb_reg_write_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic rdb, input logic wr, input logic rw);
        valid_i = v; alu_result_i = alu; rs2_data_i = rs2; rd_addr_i = rd;
        funct3_i = f3; mem_read_i = rdb; mem_write_i = wr; reg_write_i = rw;
    endtask

    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input int rv_wait, input logic [31:0] exp);
        drive(1'b1, a, 32'h0, rd, f3, 1'b1, 1'b0, 1'b1);
        #1;
        chk({tag, "/idle_stall"}, stall_o, 1);
        chk({tag, "/idle_req"}, dmem_req_o, 0);
        tick();
        dmem_gnt_i = 1'b1;
        #1;
        chk({tag, "/req"}, dmem_req_o, 1);
        chk({tag, "/addr"}, dmem_addr_o, {a[31:2], 2'b00});
        chk({tag, "/we"}, dmem_we_o, 0);
        chk({tag, "/req_stall"}, stall_o, 1);
        tick();
        dmem_gnt_i = 1'b0;
        chk({tag, "/wait_req"}, dmem_req_o, 0);
        for (int i = 0; i < rv_wait; i++) begin
            chk({tag, "/wait_stall"}, stall_o, 1);
            tick();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        #1;
        chk({tag, "/rv_stall"}, stall_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk({tag, "/wb_valid"}, wb_valid_o, 1);
        chk({tag, "/wb_result"}, wb_result_o, exp);
        chk({tag, "/wb_rd"}, wb_rd_addr_o, rd);
        chk({tag, "/wb_regw"}, wb_reg_write_o, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst/req", dmem_req_o, 0);
        chk("rst/stall", stall_o, 0);
        chk("rst/wb_valid", wb_valid_o, 0);
        chk("rst/wb_result", wb_result_o, 0);
        chk("rst/misal", misaligned_o, 0);
        chk("rst/buserr", bus_err_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // pass-through ADD, then rd=0 write suppression, then bubble
        drive(1'b1, 32'h0000_1234, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("add/stall", stall_o, 0);
        tick();
        chk("add/wb_valid", wb_valid_o, 1);
        chk("add/wb_result", wb_result_o, 32'h0000_1234);
        chk("add/wb_rd", wb_rd_addr_o, 5);
        chk("add/wb_regw", wb_reg_write_o, 1);
        drive(1'b1, 32'h0000_0055, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("add0/stall", stall_o, 0);
        tick();
        chk("add0/wb_valid", wb_valid_o, 1);
        chk("add0/wb_result", wb_result_o, 32'h0000_0055);
        chk("add0/wb_regw", wb_reg_write_o, 0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bubble/wb_valid", wb_valid_o, 0);
        chk("bubble/wb_regw", wb_reg_write_o, 0);

        // loads: byte/half, signed/unsigned
        run_load("lb", 32'h0000_0103, 3'b000, 5'd7, 32'h80FF_0000, 1, 32'hFFFF_FF80);
        run_load("lbu", 32'h0000_0103, 3'b100, 5'd7, 32'h80FF_0000, 1, 32'h0000_0080);
        run_load("lh", 32'h0000_0102, 3'b001, 5'd8, 32'h80FF_0000, 0, 32'hFFFF_80FF);
        run_load("lhu", 32'h0000_0102, 3'b101, 5'd8, 32'h80FF_0000, 0, 32'h0000_80FF);

        // SH with gnt held off for 3 cycles
        drive(1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
        #1;
        chk("sh/idle_stall", stall_o, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sh/req", dmem_req_o, 1);
            chk("sh/we", dmem_we_o, 1);
            chk("sh/addr", dmem_addr_o, 32'h0000_0200);
            chk("sh/be", dmem_be_o, 4'b1100);
            chk("sh/wdata", dmem_wdata_o, 32'hBEEF_BEEF);
            chk("sh/stall", stall_o, 1);
            tick();
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("sh/gnt_stall", stall_o, 0);
        chk("sh/gnt_be", dmem_be_o, 4'b1100);
        tick();
        dmem_gnt_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("sh/wb_valid", wb_valid_o, 1);
        chk("sh/wb_regw", wb_reg_write_o, 0);
        chk("sh/req_after", dmem_req_o, 0);

        // SB at lane 1, immediate gnt
        drive(1'b1, 32'h0000_0201, 32'h1234_56AB, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        dmem_gnt_i = 1'b1;
        #1;
        chk("sb/be", dmem_be_o, 4'b0010);
        chk("sb/wdata", dmem_wdata_o, 32'hABAB_ABAB);
        chk("sb/stall", stall_o, 0);
        tick();
        dmem_gnt_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("sb/wb_valid", wb_valid_o, 1);

        // misaligned LW and illegal-funct3 store
        drive(1'b1, 32'h0000_0401, 32'h0, 5'd4, 3'b010, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lwmis/stall", stall_o, 0);
        chk("lwmis/req", dmem_req_o, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("lwmis/misal", misaligned_o, 1);
        chk("lwmis/wb_valid", wb_valid_o, 1);
        chk("lwmis/wb_regw", wb_reg_write_o, 0);
        chk("lwmis/req2", dmem_req_o, 0);
        tick();
        chk("lwmis/pulse", misaligned_o, 0);
        drive(1'b1, 32'h0000_0000, 32'h0, 5'd0, 3'b011, 1'b0, 1'b1, 1'b0);
        #1;
        chk("st011/stall", stall_o, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("st011/misal", misaligned_o, 1);
        chk("st011/req", dmem_req_o, 0);

        // LW with gnt but no rvalid: timeout abort
        drive(1'b1, 32'h0000_0300, 32'h0, 5'd6, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        n = 0;
        dmem_gnt_i = 1'b1;
        tick();
        n = 1;
        dmem_gnt_i = 1'b0;
        while (bus_err_o !== 1'b1 && n < 40) begin
            if (n == 10) chk("to/stall_mid", stall_o, 1);
            tick();
            n++;
        end
        chk("to/cycles", n, 15);
        chk("to/wb_valid", wb_valid_o, 1);
        chk("to/wb_regw", wb_reg_write_o, 0);
        chk("to/req", dmem_req_o, 0);
        drive(1'b1, 32'h0000_0077, 32'h0, 5'd3, 3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("to_add/stall", stall_o, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("to_add/buserr", bus_err_o, 0);
        chk("to_add/wb_result", wb_result_o, 32'h0000_0077);
        chk("to_add/wb_regw", wb_reg_write_o, 1);

        // reset while in WAIT
        drive(1'b1, 32'h0000_0000, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("rstw/stall_before", stall_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw/req", dmem_req_o, 0);
        chk("rstw/stall", stall_o, 0);
        chk("rstw/wb_valid", wb_valid_o, 0);
        chk("rstw/wb_result", wb_result_o, 0);
        chk("rstw/wb_rd", wb_rd_addr_o, 0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        run_load("lw_post", 32'h0000_0000, 3'b010, 5'd9, 32'h1122_3344, 0, 32'h1122_3344);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
